// File: rtl/rvfi_csr_seq_check.sv
// Shadow-CSR sequence checker: tracks one CSR across retired instructions and flags reads
// that disagree with the last write. Optional rvfi_order continuity check: RISCV_FORMAL_CSRSEQ_ORDER_EN.
module rvfi_csr_seq_check #(
  parameter int          XLEN      = 32,
  parameter int          NRET      = 1,
  parameter logic [11:0] CSR_INDEX = 12'hB00,
  parameter int          COUNTER   = 0
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   check,
  input  logic [NRET-1:0]                        rvfi_valid,
  input  logic [64*NRET-1:0]                     rvfi_order,
  input  logic [XLEN*NRET-1:0]                   rvfi_csr_rmask,
  input  logic [XLEN*NRET-1:0]                   rvfi_csr_wmask,
  input  logic [XLEN*NRET-1:0]                   rvfi_csr_rdata,
  input  logic [XLEN*NRET-1:0]                   rvfi_csr_wdata,
  output logic                                   fail,
  output logic [(NRET > 1 ? $clog2(NRET) : 1)-1:0] fail_chan,
  output logic [63:0]                            fail_order,
  output logic [15:0]                            access_cnt
);
  localparam int CW = (NRET > 1) ? $clog2(NRET) : 1;

  typedef enum logic [1:0] {S_EMPTY, S_TRACK, S_FAILED} state_t;

  state_t state_reg, state_next;
  logic [XLEN-1:0] shadow_reg, shadow_next;
  logic [XLEN-1:0] known_reg, known_next;
  logic [CW-1:0]   fail_chan_reg, fail_chan_next;
  logic [63:0]     fail_order_reg, fail_order_next;
  logic [15:0]     access_cnt_reg, access_cnt_next;

  logic [63:0]     order_ch [NRET];
  logic [XLEN-1:0] rmask_ch [NRET];
  logic [XLEN-1:0] wmask_ch [NRET];
  logic [XLEN-1:0] rdata_ch [NRET];
  logic [XLEN-1:0] wdata_ch [NRET];

  genvar gi;
  generate
    for (gi = 0; gi < NRET; gi++) begin : g_unpack
      assign order_ch[gi] = rvfi_order[gi*64 +: 64];
      assign rmask_ch[gi] = rvfi_csr_rmask[gi*XLEN +: XLEN];
      assign wmask_ch[gi] = rvfi_csr_wmask[gi*XLEN +: XLEN];
      assign rdata_ch[gi] = rvfi_csr_rdata[gi*XLEN +: XLEN];
      assign wdata_ch[gi] = rvfi_csr_wdata[gi*XLEN +: XLEN];
    end
  endgenerate

`ifdef RISCV_FORMAL_CSRSEQ_ORDER_EN
  logic [63:0] last_order_reg, last_order_next;
  logic        order_seen_reg, order_seen_next;
`endif

  logic            bad;
  logic            found;
  logic            any_write;
  logic [16:0]     acc_sum;
  logic [XLEN-1:0] diff;

  // Channels are walked oldest first so each sees the shadow as left by its predecessors.
  always_comb begin
    shadow_next     = shadow_reg;
    known_next      = known_reg;
    found           = 1'b0;
    any_write       = 1'b0;
    bad             = 1'b0;
    diff            = '0;
    fail_chan_next  = fail_chan_reg;
    fail_order_next = fail_order_reg;
    acc_sum         = {1'b0, access_cnt_reg};
`ifdef RISCV_FORMAL_CSRSEQ_ORDER_EN
    last_order_next = last_order_reg;
    order_seen_next = order_seen_reg;
`endif
    for (int i = 0; i < NRET; i++) begin
      if (rvfi_valid[i]) begin
        bad = 1'b0;
        if (COUNTER == 0) begin
          bad = ((rdata_ch[i] ^ shadow_next) & rmask_ch[i] & known_next) != '0;
        end else if ((&known_next) && (&rmask_ch[i])) begin
          diff        = rdata_ch[i] - shadow_next;
          bad         = diff[XLEN-1];
          shadow_next = rdata_ch[i];
        end
`ifdef RISCV_FORMAL_CSRSEQ_ORDER_EN
        if (order_seen_next && (order_ch[i] != last_order_next + 64'd1))
          bad = 1'b1;
        last_order_next = order_ch[i];
        order_seen_next = 1'b1;
`endif
        shadow_next = (shadow_next & ~wmask_ch[i]) | (wdata_ch[i] & wmask_ch[i]);
        known_next  = known_next | wmask_ch[i];
        if (wmask_ch[i] != '0)
          any_write = 1'b1;
        if ((rmask_ch[i] | wmask_ch[i]) != '0)
          acc_sum = acc_sum + 17'd1;
        if (bad && check && !found) begin
          found           = 1'b1;
          fail_chan_next  = CW'(i);
          fail_order_next = order_ch[i];
        end
      end
    end
    access_cnt_next = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
    if (state_reg == S_FAILED) begin
      fail_chan_next  = fail_chan_reg;
      fail_order_next = fail_order_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_EMPTY:  if (found) state_next = S_FAILED;
                else if (any_write) state_next = S_TRACK;
      S_TRACK:  if (found) state_next = S_FAILED;
      S_FAILED: state_next = S_FAILED;
      default:  state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= S_EMPTY;
      shadow_reg     <= '0;
      known_reg      <= '0;
      fail_chan_reg  <= '0;
      fail_order_reg <= '0;
      access_cnt_reg <= '0;
`ifdef RISCV_FORMAL_CSRSEQ_ORDER_EN
      last_order_reg <= '0;
      order_seen_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      shadow_reg     <= shadow_next;
      known_reg      <= known_next;
      fail_chan_reg  <= fail_chan_next;
      fail_order_reg <= fail_order_next;
      access_cnt_reg <= access_cnt_next;
`ifdef RISCV_FORMAL_CSRSEQ_ORDER_EN
      last_order_reg <= last_order_next;
      order_seen_reg <= order_seen_next;
`endif
    end
  end

  always_comb begin
    fail       = (state_reg == S_FAILED);
    fail_chan  = fail_chan_reg;
    fail_order = fail_order_reg;
    access_cnt = access_cnt_reg;
  end

  csr_first_fail_cover: cover property (@(posedge clock) disable iff (reset)
    (state_reg != S_FAILED) && found && (CSR_INDEX <= 12'hFFF));

endmodule

// File: tb/tb_rvfi_csr_seq_check.sv
// Scoreboard bench for rvfi_csr_seq_check: a two-channel ordinary instance and a
// single-channel counter instance, driven with directed vectors.
module tb_rvfi_csr_seq_check;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic         a_check, b_check;
  logic [1:0]   a_valid;
  logic [127:0] a_order;
  logic [63:0]  a_rmask, a_wmask, a_rdata, a_wdata;
  logic         a_fail;
  logic [0:0]   a_fail_chan;
  logic [63:0]  a_fail_order;
  logic [15:0]  a_access_cnt;

  logic [0:0]   b_valid;
  logic [63:0]  b_order;
  logic [31:0]  b_rmask, b_wmask, b_rdata, b_wdata;
  logic         b_fail;
  logic [0:0]   b_fail_chan;
  logic [63:0]  b_fail_order;
  logic [15:0]  b_access_cnt;

  rvfi_csr_seq_check #(.XLEN(32), .NRET(2), .CSR_INDEX(12'h300), .COUNTER(0)) dut_a (
    .clock(clock), .reset(reset), .check(a_check), .rvfi_valid(a_valid), .rvfi_order(a_order),
    .rvfi_csr_rmask(a_rmask), .rvfi_csr_wmask(a_wmask), .rvfi_csr_rdata(a_rdata),
    .rvfi_csr_wdata(a_wdata), .fail(a_fail), .fail_chan(a_fail_chan),
    .fail_order(a_fail_order), .access_cnt(a_access_cnt));

  rvfi_csr_seq_check #(.XLEN(32), .NRET(1), .CSR_INDEX(12'hB00), .COUNTER(1)) dut_b (
    .clock(clock), .reset(reset), .check(b_check), .rvfi_valid(b_valid), .rvfi_order(b_order),
    .rvfi_csr_rmask(b_rmask), .rvfi_csr_wmask(b_wmask), .rvfi_csr_rdata(b_rdata),
    .rvfi_csr_wdata(b_wdata), .fail(b_fail), .fail_chan(b_fail_chan),
    .fail_order(b_fail_order), .access_cnt(b_access_cnt));

  typedef struct {
    string       name;
    logic        f;
    logic        ch;
    logic [63:0] ord;
    logic [15:0] cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   failures = 0;
  bit   quiet = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic compare(input string inst, input exp_t e, input logic f, input logic ch,
                         input logic [63:0] ord, input logic [15:0] cnt);
    $display("txn %s/%s fail=%0d chan=%0d order=%0d cnt=%0d", inst, e.name, f, ch, ord, cnt);
    chk({inst, "/", e.name, ".fail"}, 64'(f), 64'(e.f));
    chk({inst, "/", e.name, ".fail_chan"}, 64'(ch), 64'(e.ch));
    chk({inst, "/", e.name, ".fail_order"}, ord, e.ord);
    chk({inst, "/", e.name, ".access_cnt"}, 64'(cnt), 64'(e.cnt));
  endtask

  // Monitors: a retirement at a posedge yields a registered response just after it.
  initial forever begin
    @(posedge clock);
    if (|a_valid && !quiet) begin
      #1;
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_queue_empty actual=0 expected=1");
      end else compare("a", qa.pop_front(), a_fail, a_fail_chan, a_fail_order, a_access_cnt);
    end
  end

  initial forever begin
    @(posedge clock);
    if (b_valid[0]) begin
      #1;
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_queue_empty actual=0 expected=1");
      end else compare("b", qb.pop_front(), b_fail, b_fail_chan, b_fail_order, b_access_cnt);
    end
  end

  task automatic clear_inputs();
    a_check = 1'b1; a_valid = '0; a_order = '0;
    a_rmask = '0; a_wmask = '0; a_rdata = '0; a_wdata = '0;
    b_check = 1'b1; b_valid = '0; b_order = '0;
    b_rmask = '0; b_wmask = '0; b_rdata = '0; b_wdata = '0;
  endtask

  task automatic begin_cyc();
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic set_ch(input int c, input logic [63:0] o, input logic [31:0] rm,
                        input logic [31:0] wm, input logic [31:0] rd, input logic [31:0] wd);
    a_valid[c]         = 1'b1;
    a_order[c*64 +: 64] = o;
    a_rmask[c*32 +: 32] = rm;
    a_wmask[c*32 +: 32] = wm;
    a_rdata[c*32 +: 32] = rd;
    a_wdata[c*32 +: 32] = wd;
  endtask

  task automatic push_a(input string n, input logic f, input logic ch,
                        input logic [63:0] o, input logic [15:0] c);
    exp_t e;
    e.name = n; e.f = f; e.ch = ch; e.ord = o; e.cnt = c;
    qa.push_back(e);
  endtask

  task automatic send_b(input string n, input logic [63:0] o, input logic [31:0] rm,
                        input logic [31:0] wm, input logic [31:0] rd, input logic [31:0] wd,
                        input logic f, input logic [63:0] eo, input logic [15:0] c);
    exp_t e;
    begin_cyc();
    b_valid = 1'b1; b_order = o; b_rmask = rm; b_wmask = wm; b_rdata = rd; b_wdata = wd;
    e.name = n; e.f = f; e.ch = 1'b0; e.ord = eo; e.cnt = c;
    qb.push_back(e);
  endtask

  // Reset lands between edges so the asynchronous clear is observed without a clock.
  task automatic do_reset(input string n);
    @(negedge clock);
    clear_inputs();
    #1 reset = 1'b1;
    #1;
    chk({n, ".a_fail"}, 64'(a_fail), 64'd0);
    chk({n, ".a_fail_chan"}, 64'(a_fail_chan), 64'd0);
    chk({n, ".a_fail_order"}, a_fail_order, 64'd0);
    chk({n, ".a_access_cnt"}, 64'(a_access_cnt), 64'd0);
    chk({n, ".b_fail"}, 64'(b_fail), 64'd0);
    chk({n, ".b_access_cnt"}, 64'(b_access_cnt), 64'd0);
    @(negedge clock);
    #1 reset = 1'b0;
  endtask

  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  initial begin
    clear_inputs();
    do_reset("reset_initial");

    // Single-channel write/read, then a mismatch at order 7; later mismatch stays frozen.
    begin_cyc(); set_ch(0, 5, 0, ALL, 0, 32'h1234_5678);     push_a("wr", 0, 0, 0, 1);
    begin_cyc(); set_ch(0, 6, ALL, 0, 32'h1234_5678, 0);     push_a("rd_ok", 0, 0, 0, 2);
    begin_cyc(); set_ch(0, 7, ALL, 0, 32'h1234_5679, 0);     push_a("rd_bad", 1, 0, 7, 3);
    begin_cyc(); set_ch(0, 8, ALL, 0, 32'h0, 0);             push_a("frozen", 1, 0, 7, 4);
    do_reset("reset_midstream");

    // Two channels: same-cycle forwarding, then simultaneous mismatches.
    begin_cyc(); set_ch(0, 0, 0, ALL, 0, 32'hA); set_ch(1, 1, ALL, 0, 32'hA, 0);
    push_a("fwd", 0, 0, 0, 2);
    begin_cyc(); set_ch(0, 2, ALL, 0, 32'hB, 0); set_ch(1, 3, ALL, 0, 32'hC, 0);
    push_a("dual_bad", 1, 0, 2, 4);
    do_reset("reset_dual");

    // Partial knowledge, read+write on one channel, check=0, failure on channel 1.
    begin_cyc(); set_ch(0, 9, ALL, 0, 32'h1234, 0);                  push_a("empty_rd", 0, 0, 0, 1);
    begin_cyc(); set_ch(0, 10, 0, 32'h0000_00FF, 0, 32'h5A);         push_a("wr_byte", 0, 0, 0, 2);
    begin_cyc(); set_ch(0, 11, ALL, 0, 32'hDEAD_BE5A, 0);            push_a("rd_partial", 0, 0, 0, 3);
    begin_cyc(); set_ch(0, 12, ALL, ALL, 32'h0000_005A, 32'h77);     push_a("rd_wr", 0, 0, 0, 4);
    begin_cyc(); a_check = 1'b0; set_ch(0, 13, ALL, 0, 32'h78, 0);   push_a("nocheck", 0, 0, 0, 5);
    begin_cyc(); set_ch(1, 14, ALL, 0, 32'h78, 0);                   push_a("ch1_bad", 1, 1, 14, 6);
    do_reset("reset_partial");

`ifdef RISCV_FORMAL_CSRSEQ_ORDER_EN
    begin_cyc(); set_ch(0, 3, ALL, 0, 0, 0); push_a("ord3", 0, 0, 0, 1);
    begin_cyc(); set_ch(0, 4, ALL, 0, 0, 0); push_a("ord4", 0, 0, 0, 2);
    begin_cyc(); set_ch(0, 6, ALL, 0, 0, 0); push_a("ord6_gap", 1, 0, 6, 3);
    do_reset("reset_order");
`endif

    // access_cnt saturation: 65534 silent accesses, then two scored cycles.
    quiet = 1'b1;
    for (int k = 0; k < 32767; k++) begin
      begin_cyc();
      set_ch(0, 64'(2 * k), ALL, 0, 0, 0);
      set_ch(1, 64'(2 * k + 1), ALL, 0, 0, 0);
    end
    begin_cyc(); quiet = 1'b0;
    set_ch(0, 65534, ALL, 0, 0, 0); set_ch(1, 65535, ALL, 0, 0, 0);
    push_a("sat", 0, 0, 0, 16'hFFFF);
    begin_cyc(); set_ch(0, 65536, ALL, 0, 0, 0);       push_a("sat_hold", 0, 0, 0, 16'hFFFF);
    do_reset("reset_sat");

    // Counter mode: forward moves and wrap legal, writes unchecked, backward step fails.
    send_b("c_wr",     0, 0,   ALL, 0,            32'hFFFF_FFF0, 0, 0, 1);
    send_b("c_fwd",    1, ALL, 0,   32'hFFFF_FFFE, 0,            0, 0, 2);
    send_b("c_wrap",   2, ALL, 0,   32'h0000_0003, 0,            0, 0, 3);
    send_b("c_wr_low", 3, 0,   ALL, 0,            32'h0000_0001, 0, 0, 4);
    send_b("c_step",   4, ALL, 0,   32'h0000_0002, 0,            0, 0, 5);
    send_b("c_back",   5, ALL, 0,   32'h0000_0001, 0,            1, 5, 6);

    begin_cyc();
    begin_cyc();
    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_queue_drained", 64'(qb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
